jtkcpu_idxgen: RTL and testbench



---
 rtl/jtkcpu_idxgen.sv | 153 +++++++++++++++
 tb/tb_jtkcpu_idxgen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_idxgen.sv
// KCPU indexed-mode effective-address generator: offset/auto-inc/dec address math,
// register write-back and a two-byte indirect pointer fetch. Optional: JTKCPU_IDX_ABORT_EN.
module jtkcpu_idxgen #(
    parameter int AW    = 16,
    parameter bit PCCOR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [1:0]    step,
    input  logic          indirect,
    input  logic          pcrel,
    input  logic [AW-1:0] idx_reg,
    input  logic [15:0]   idx_racc,
    input  logic [15:0]   mdata,
    input  logic [7:0]    dp,
    input  logic          rd_ack,
    input  logic          abort,
    output logic [AW-1:0] addr,
    output logic          rd_req,
    output logic [AW-1:0] reg_nxt,
    output logic          reg_wr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        MD_REG, MD_OFS8, MD_OFS16, MD_ACC, MD_DP, MD_EXT, MD_POSTINC, MD_PREDEC
    } mode_t;

    // state is kept as a named enum so checkers can bind to it directly
    typedef enum logic [1:0] {IDLE, IND_HI, IND_LO} state_t;

    // Handshake: the sequencer pulses start while idle; done (one cen cycle) marks addr
    // final. During an indirect fetch rd_req stays high at addr and each cen cycle with
    // rd_ack consumes mdata[7:0]; rd_ack outside a fetch is ignored.

    state_t        state, state_d;
    logic [AW-1:0] offset, step_amt, ea, inc_val;
    logic [AW-1:0] addr_d, reg_nxt_d;
    logic [7:0]    hi, hi_d;
    logic          rd_req_d, reg_wr_d, done_d, abort_hit;

`ifdef JTKCPU_IDX_ABORT_EN
    assign abort_hit = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    always_comb begin
        offset = '0;
        case (mode_t'(mode))
            MD_OFS8:  offset = AW'($signed(mdata[7:0]));
            MD_OFS16: offset = AW'($signed(mdata));
            MD_ACC:   offset = AW'($signed(idx_racc));
            default:  offset = '0;
        endcase
        // PC has already advanced past the offset bytes when idx_reg is the PC
        if (PCCOR && pcrel) begin
            if (mode_t'(mode) == MD_OFS8)  offset = offset - AW'(1);
            if (mode_t'(mode) == MD_OFS16) offset = offset - AW'(2);
        end
        step_amt = step[1] ? AW'(2) : AW'(1);
        inc_val  = (mode_t'(mode) == MD_PREDEC) ? idx_reg - step_amt : idx_reg + step_amt;
        case (mode_t'(mode))
            MD_DP:      ea = AW'({dp, mdata[7:0]});
            MD_EXT:     ea = AW'(mdata);
            MD_POSTINC: ea = idx_reg;
            MD_PREDEC:  ea = inc_val;
            default:    ea = idx_reg + offset;
        endcase
    end

    always_comb begin
        state_d   = state;
        addr_d    = addr;
        hi_d      = hi;
        rd_req_d  = rd_req;
        reg_nxt_d = reg_nxt;
        reg_wr_d  = 1'b0;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_d = ea;
                    if (mode_t'(mode) == MD_POSTINC || mode_t'(mode) == MD_PREDEC) begin
                        reg_wr_d  = 1'b1;
                        reg_nxt_d = inc_val;
                    end
                    if (indirect) begin
                        state_d  = IND_HI;
                        rd_req_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            IND_HI: begin
                if (abort_hit) begin
                    state_d  = IDLE;
                    rd_req_d = 1'b0;
                end else if (rd_ack) begin
                    hi_d    = mdata[7:0];
                    addr_d  = addr + AW'(1);
                    state_d = IND_LO;
                end
            end
            IND_LO: begin
                if (abort_hit) begin
                    state_d  = IDLE;
                    rd_req_d = 1'b0;
                end else if (rd_ack) begin
                    addr_d   = AW'({hi, mdata[7:0]});
                    rd_req_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                rd_req_d = 1'b0;
            end
        endcase
    end

    // pulses are registered under cen so they hold through cen=0 gaps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= '0;
            hi      <= '0;
            rd_req  <= 1'b0;
            reg_nxt <= '0;
            reg_wr  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (cen) begin
            state   <= state_d;
            addr    <= addr_d;
            hi      <= hi_d;
            rd_req  <= rd_req_d;
            reg_nxt <= reg_nxt_d;
            reg_wr  <= reg_wr_d;
            busy    <= (state_d != IDLE);
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_jtkcpu_idxgen.sv
// Bench for jtkcpu_idxgen: AW=16 and AW=20 instances share stimulus; a per-cycle
// arithmetic model is checked continuously, with hand-computed literal spot checks.
module tb_jtkcpu_idxgen;

    logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b0, start = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [1:0]  step = 2'd1;
    logic        indirect = 1'b0, pcrel = 1'b0, rd_ack = 1'b0, abort = 1'b0;
    logic [23:0] idx = '0;
    logic [15:0] racc = '0, mdata = '0;
    logic [7:0]  dp = '0;

    logic [15:0] addr16, nxt16;
    logic [19:0] addr20, nxt20;
    logic        rdreq16, wr16, busy16, done16;
    logic        rdreq20, wr20, busy20, done20;

    int n_pass = 0, n_total = 0;
    bit chk_en = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    jtkcpu_idxgen #(.AW(16), .PCCOR(1'b1)) dut16 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .mode(mode), .step(step),
        .indirect(indirect), .pcrel(pcrel), .idx_reg(idx[15:0]), .idx_racc(racc),
        .mdata(mdata), .dp(dp), .rd_ack(rd_ack), .abort(abort), .addr(addr16),
        .rd_req(rdreq16), .reg_nxt(nxt16), .reg_wr(wr16), .busy(busy16), .done(done16));

    jtkcpu_idxgen #(.AW(20), .PCCOR(1'b1)) dut20 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .mode(mode), .step(step),
        .indirect(indirect), .pcrel(pcrel), .idx_reg(idx[19:0]), .idx_racc(racc),
        .mdata(mdata), .dp(dp), .rd_ack(rd_ack), .abort(abort), .addr(addr20),
        .rd_req(rdreq20), .reg_nxt(nxt20), .reg_wr(wr20), .busy(busy20), .done(done20));

    // ---------------- model ----------------
    int     aw_of [2] = '{16, 20};
    longint m_addr [2], m_nxt [2], m_hi [2];
    int     m_phase [2];            // 0 idle, 1 awaiting high byte, 2 awaiting low byte
    bit     m_wr [2], m_done [2], m_busy [2], m_rdreq [2];
`ifdef JTKCPU_IDX_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    function automatic longint mask_of(int aw);
        return (longint'(1) << aw) - 1;
    endfunction

    function automatic longint step_of();
        return (step >= 2) ? 2 : 1;
    endfunction

    function automatic longint model_ea(int aw);
        longint base = longint'(idx) & mask_of(aw);
        longint off = 0;
        case (mode)
            3'd1: begin off = longint'($signed(mdata[7:0])); if (pcrel) off -= 1; end
            3'd2: begin off = longint'($signed(mdata));      if (pcrel) off -= 2; end
            3'd3: off = longint'($signed(racc));
            3'd4: return longint'(dp) * 256 + longint'(mdata[7:0]);
            3'd5: return longint'(mdata);
            3'd6: return base;
            3'd7: return (base - step_of()) & mask_of(aw);
            default: off = 0;
        endcase
        return (base + off) & mask_of(aw);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_addr[i] = 0; m_nxt[i] = 0; m_hi[i] = 0; m_phase[i] = 0;
                m_wr[i] = 0; m_done[i] = 0; m_busy[i] = 0; m_rdreq[i] = 0;
            end
        end else if (cen) begin
            for (int i = 0; i < 2; i++) begin
                m_wr[i] = 0;
                m_done[i] = 0;
                if (m_phase[i] == 0) begin
                    if (start) begin
                        m_addr[i] = model_ea(aw_of[i]);
                        if (mode == 3'd6) begin
                            m_wr[i] = 1; m_nxt[i] = (longint'(idx) + step_of()) & mask_of(aw_of[i]);
                        end else if (mode == 3'd7) begin
                            m_wr[i] = 1; m_nxt[i] = m_addr[i];
                        end
                        if (indirect) m_phase[i] = 1;
                        else m_done[i] = 1;
                    end
                end else if (ABORT_ON && abort) begin
                    m_phase[i] = 0;
                end else if (rd_ack && m_phase[i] == 1) begin
                    m_hi[i] = longint'(mdata[7:0]);
                    m_addr[i] = (m_addr[i] + 1) & mask_of(aw_of[i]);
                    m_phase[i] = 2;
                end else if (rd_ack) begin
                    m_addr[i] = m_hi[i] * 256 + longint'(mdata[7:0]);
                    m_phase[i] = 0;
                    m_done[i] = 1;
                end
                m_busy[i] = (m_phase[i] != 0);
                m_rdreq[i] = m_busy[i];
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && chk_en) begin
            cmp("addr16", addr16, m_addr[0]);  cmp("addr20", addr20, m_addr[1]);
            cmp("nxt16", nxt16, m_nxt[0]);     cmp("nxt20", nxt20, m_nxt[1]);
            cmp("wr16", wr16, m_wr[0]);        cmp("wr20", wr20, m_wr[1]);
            cmp("done16", done16, m_done[0]);  cmp("done20", done20, m_done[1]);
            cmp("busy16", busy16, m_busy[0]);  cmp("busy20", busy20, m_busy[1]);
            cmp("rdreq16", rdreq16, m_rdreq[0]); cmp("rdreq20", rdreq20, m_rdreq[1]);
        end
    end

    // ---------------- driver tasks (enter and leave at a negedge) ----------------
    task automatic start_req(input logic [2:0] m, input logic [23:0] ix,
                             input logic [15:0] md, input logic ind);
        mode = m; idx = ix; mdata = md; indirect = ind; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ack(input logic [7:0] b);
        mdata = {8'h00, b}; rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        cen = 1'b1;
        #3;
        cmp("rst_addr16", addr16, 0); cmp("rst_done16", done16, 0);
        cmp("rst_busy16", busy16, 0); cmp("rst_rdreq16", rdreq16, 0);
        idle(2);
        rst_n = 1'b1; chk_en = 1'b1;
        idle(1);

        // OFS8 negative offset, then done holds over a cen=0 gap
        start_req(3'd1, 24'h1000, 16'h00F0, 1'b0);
        cmp("t1_addr16", addr16, 16'h0FF0); cmp("t1_addr20", addr20, 20'h00FF0);
        cmp("t1_done", done16, 1); cmp("t1_wr", wr16, 0);
        cen = 1'b0; idle(1);
        cmp("t1_done_hold", done16, 1);
        cen = 1'b1; idle(1);
        cmp("t1_done_drop", done16, 0);

        // PC-relative correction (back-to-back starts)
        pcrel = 1'b1;
        start_req(3'd2, 24'h2000, 16'h0010, 1'b0);
        cmp("t2_ofs16", addr16, 16'h200E);
        racc = 16'hFFFE;
        start_req(3'd3, 24'h2000, 16'h0010, 1'b0);
        cmp("t2_acc", addr16, 16'h1FFE);
        start_req(3'd1, 24'h1000, 16'h0005, 1'b0);
        cmp("t2_ofs8", addr16, 16'h1004);
        pcrel = 1'b0;
        idle(1);

        // auto inc/dec with wrap, plus illegal step encodings
        step = 2'd2;
        start_req(3'd7, 24'h0001, 16'h0000, 1'b0);
        cmp("t3_predec_addr", addr16, 16'hFFFF); cmp("t3_predec_nxt", nxt16, 16'hFFFF);
        cmp("t3_predec_wr", wr16, 1); cmp("t3_predec_addr20", addr20, 20'hFFFFF);
        step = 2'd1;
        start_req(3'd6, 24'hFFFF, 16'h0000, 1'b0);
        cmp("t3_postinc_addr", addr16, 16'hFFFF); cmp("t3_postinc_nxt", nxt16, 16'h0000);
        cmp("t3_postinc_nxt20", nxt20, 20'h10000);
        step = 2'd0;
        start_req(3'd6, 24'h0100, 16'h0000, 1'b0);
        cmp("t3_step0", nxt16, 16'h0101);
        step = 2'd3;
        start_req(3'd7, 24'h0100, 16'h0000, 1'b0);
        cmp("t3_step3", addr16, 16'h00FE);
        idle(1);

        // indirect EXT with two stall cycles
        start_req(3'd5, 24'h0, 16'h3000, 1'b1);
        cmp("t4_ptr", addr16, 16'h3000); cmp("t4_rdreq", rdreq16, 1); cmp("t4_busy", busy16, 1);
        ack(8'h12);
        cmp("t4_ptr1", addr16, 16'h3001);
        mdata = 16'h5555; idle(2);
        cmp("t4_stall_busy", busy16, 1);
        ack(8'h34);
        cmp("t4_final", addr16, 16'h1234); cmp("t4_done", done16, 1); cmp("t4_busy_end", busy16, 0);
        ack(8'h77);   // ignored in IDLE
        idle(1);

        // direct page on AW=20, start ignored during a fetch
        dp = 8'hA5;
        start_req(3'd4, 24'h0, 16'h003C, 1'b0);
        cmp("t5_dp20", addr20, 20'h0A53C); cmp("t5_dp16", addr16, 16'hA53C);
        idle(1);
        start_req(3'd0, 24'h4000, 16'h0000, 1'b1);
        start_req(3'd5, 24'h0, 16'h7777, 1'b0);
        cmp("t5_ignored", addr16, 16'h4000); cmp("t5_ignored_done", done16, 0);
        ack(8'h56); ack(8'h78);
        cmp("t5_final", addr16, 16'h5678);
        idle(1);

        // indirect POSTINC: write-back at start, ack during cen=0 has no effect
        step = 2'd2;
        start_req(3'd6, 24'h8000, 16'h0000, 1'b1);
        cmp("t5_ind_wr", wr16, 1); cmp("t5_ind_nxt", nxt16, 16'h8002);
        ack(8'hAB);
        mdata = 16'h00EE; rd_ack = 1'b1; cen = 1'b0; idle(1); cen = 1'b1; rd_ack = 1'b0;
        ack(8'hCD);
        cmp("t5_ind_final", addr16, 16'hABCD);
        idle(1);

        // abort in IND_LO
        start_req(3'd5, 24'h0, 16'h3000, 1'b1);
        ack(8'h12);
        abort = 1'b1; idle(1); abort = 1'b0;
`ifdef JTKCPU_IDX_ABORT_EN
        cmp("t6_abort_addr", addr16, 16'h3001); cmp("t6_abort_busy", busy16, 0);
        cmp("t6_abort_done", done16, 0);
`else
        cmp("t6_noabort_busy", busy16, 1);
        ack(8'h34);
        cmp("t6_noabort_addr", addr16, 16'h1234);
`endif
        idle(1);
        // abort and rd_ack together in IND_HI
        start_req(3'd5, 24'h0, 16'h2000, 1'b1);
        mdata = 16'h0099; rd_ack = 1'b1; abort = 1'b1; idle(1); rd_ack = 1'b0; abort = 1'b0;
        ack(8'h11);
        idle(1);

        // reset mid-fetch
        start_req(3'd5, 24'h0, 16'h3000, 1'b1);
        ack(8'h12);
        #2 rst_n = 1'b0;
        #1;
        cmp("t6_rst_addr", addr16, 0); cmp("t6_rst_nxt", nxt16, 0); cmp("t6_rst_busy", busy16, 0);
        cmp("t6_rst_rdreq", rdreq16, 0); cmp("t6_rst_addr20", addr20, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_req(3'd0, 24'h1234, 16'h0000, 1'b0);
        cmp("t6_after_rst", addr16, 16'h1234);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
